source_para_bank: RTL
=====================

Name: source_para_bank

Overview:
Multi-channel source-parameter register bank. It generalises per-channel parameter latching to NUM_CH channels, each with a shadow/active register pair.
- Writes arrive over a valid/ready config port and are held in the channel's shadow register.
- A write is applied to the active set only at that channel's packet boundary, so a running packet never sees its parameters change mid-frame.
- The block sits between the host config decoder and the per-channel packet generators.

Parameters:
NUM_CH, 8, number of channels (1..256)
CH_W, 8, width of channel index ports
CH_BASE, 0, channel number mapped to slot 0; valid channels are CH_BASE..CH_BASE+NUM_CH-1
HEAD_W, 32, packet head width
FLAG_W, 16, flag field width
LEN_W, 24, length field width

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted this cycle when high with cfg_valid
cfg_channel  in  CH_W  target channel number
cfg_head  in  HEAD_W  packet head value
cfg_flag  in  FLAG_W  flag value
cfg_length  in  LEN_W  length value
cfg_scramble  in  1  scramble enable
cfg_err  out  1  one-cycle pulse: out-of-range channel write dropped
pkt_boundary  in  NUM_CH  per-channel packet-boundary strobe from generators
act_head  out  NUM_CH*HEAD_W  active heads, channel slot i at bits [i*HEAD_W +: HEAD_W]
act_flag  out  NUM_CH*FLAG_W  active flags, same packing
act_length  out  NUM_CH*LEN_W  active lengths, same packing
act_scramble  out  NUM_CH  active scramble bits
pending  out  NUM_CH  shadow holds an unapplied write
updated  out  NUM_CH  one-cycle pulse: active set loaded this cycle
rd_channel  in  CH_W  readback channel select
rd_head / rd_flag / rd_length / rd_scramble  out  HEAD_W / FLAG_W / LEN_W / 1  registered readback of active set

Behaviour:
Slot index:
- slot = cfg_channel - CH_BASE, computed at CH_W+1 bits.
- The channel is in range when cfg_channel >= CH_BASE and slot < NUM_CH.

cfg_ready (combinational):
- 0 while rst is high.
- Otherwise 1 if cfg_channel is out of range, or if pending[slot] is 0.
- Exactly 0 when the target slot already holds an unapplied write; a pending shadow is never overwritten.

Accepted write (cfg_valid and cfg_ready):
- In range: shadow[slot] <= cfg fields; pending[slot] <= 1 on the next edge.
- Out of range: nothing is stored; cfg_err = 1 for one cycle, registered, visible the cycle after acceptance.

Per-slot state machine, state = pending bit:
- IDLE (pending 0) -> ARMED (pending 1) on an accepted write.
- ARMED -> IDLE on pkt_boundary[i]. At that edge: active[i] <= shadow[i] and updated[i] <= 1 for one cycle.
- pkt_boundary[i] in IDLE has no effect; updated stays 0.

Simultaneous events:
- Boundary and write to the same slot in ARMED: cfg_ready is 0, so the write stalls. The master retries and is accepted the cycle after the apply.
- Boundary on slot i while writing slot j (j != i) both take effect independently.
- Multiple boundaries in the same cycle are all applied.

Outputs and timing:
- act_* are driven directly from the active registers.
- Write-to-apply latency is at least 1 cycle: an accepted write plus a boundary on the next cycle gives updated on the cycle after that.
- Readback: rd_* <= active[rd_channel - CH_BASE], 1-cycle latency. An out-of-range rd_channel returns all zeros.

Reset (synchronous):
- All active registers, shadow registers, pending, updated, cfg_err and rd_* are 0.
- rst asserted mid-operation discards pending writes; no apply occurs on that edge even if pkt_boundary is high.

Optional Feature:
Macro: SRC_PARA_IMMEDIATE_EN
- Defined: adds input port cfg_immediate (1 bit). An accepted in-range write with cfg_immediate = 1 loads shadow and active in the same edge, pulses updated[slot], and leaves pending[slot] at 0.
  - An immediate write is accepted even when pending[slot] = 1; cfg_ready ignores pending when cfg_immediate = 1. Both the pending write and the pending flag are then discarded, replaced by the immediate value.
- Undefined: the port does not exist and all writes follow the boundary-apply path.

Test Plan:
1. Reset, then write ch 0x03 head 0xA5A5_0001 len 0x000400 -> pending[3]=1, act_head slot 3 stays 0; pulse pkt_boundary[3] -> updated[3] pulses for 1 cycle and act_head slot 3 = 0xA5A5_0001.
2. Two back-to-back writes to ch 5 with no boundary -> second write sees cfg_ready=0 until boundary[5]; after apply the second write is accepted and the value applies at the next boundary.
3. With CH_BASE=0x10: write to ch 0x0F and to ch 0x18 -> cfg_err pulses each time, no pending bits set, no act_* change.
4. Boundary on ch 2 in the same cycle as an accepted write to ch 6 (ch 2 armed) -> slot 2 applies and slot 6 becomes pending; no cross-corruption.
5. Arm ch 1, assert rst coincident with pkt_boundary[1] -> all act_*, pending, updated, rd_* are 0 after the edge.
6. With SRC_PARA_IMMEDIATE_EN, write ch 4 flag 0x00FF with cfg_immediate=1 while ch 4 is pending -> act_flag slot 4 = 0x00FF next cycle, pending[4]=0, rd_flag = 0x00FF one cycle after rd_channel=4.

Source files
------------

// File: rtl/source_para_bank_if.sv
// Config write port of source_para_bank (host decoder = master, bank = slave).
// cfg_immediate exists only when SRC_PARA_IMMEDIATE_EN is defined.
interface source_para_bank_if #(
  parameter int CH_W   = 8,
  parameter int HEAD_W = 32,
  parameter int FLAG_W = 16,
  parameter int LEN_W  = 24
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_channel;
  logic [HEAD_W-1:0] cfg_head;
  logic [FLAG_W-1:0] cfg_flag;
  logic [LEN_W-1:0]  cfg_length;
  logic              cfg_scramble;
  logic              cfg_err;
`ifdef SRC_PARA_IMMEDIATE_EN
  logic              cfg_immediate;
`endif

  modport master (
`ifdef SRC_PARA_IMMEDIATE_EN
    output cfg_immediate,
`endif
    output cfg_valid, cfg_channel, cfg_head, cfg_flag, cfg_length, cfg_scramble,
    input  cfg_ready, cfg_err
  );

  modport slave (
`ifdef SRC_PARA_IMMEDIATE_EN
    input  cfg_immediate,
`endif
    input  cfg_valid, cfg_channel, cfg_head, cfg_flag, cfg_length, cfg_scramble,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/source_para_bank.sv
// Multi-channel shadow/active source-parameter bank; shadow writes apply at each channel's packet boundary.
// Optional SRC_PARA_IMMEDIATE_EN adds cfg_immediate for writes that load the active set directly.
module source_para_bank #(
  parameter int NUM_CH  = 8,
  parameter int CH_W    = 8,
  parameter int CH_BASE = 0,
  parameter int HEAD_W  = 32,
  parameter int FLAG_W  = 16,
  parameter int LEN_W   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  source_para_bank_if.slave        cfg,
  input  logic [NUM_CH-1:0]        pkt_boundary,
  output logic [NUM_CH*HEAD_W-1:0] act_head,
  output logic [NUM_CH*FLAG_W-1:0] act_flag,
  output logic [NUM_CH*LEN_W-1:0]  act_length,
  output logic [NUM_CH-1:0]        act_scramble,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH-1:0]        updated,
  input  logic [CH_W-1:0]          rd_channel,
  output logic [HEAD_W-1:0]        rd_head,
  output logic [FLAG_W-1:0]        rd_flag,
  output logic [LEN_W-1:0]         rd_length,
  output logic                     rd_scramble
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} slot_state_e;

  localparam logic [CH_W:0] BASE_X = (CH_W+1)'(CH_BASE);
  localparam logic [CH_W:0] NUM_X  = (CH_W+1)'(NUM_CH);

  slot_state_e state_q [NUM_CH];
  slot_state_e state_d [NUM_CH];

  logic [NUM_CH*HEAD_W-1:0] shadow_head;
  logic [NUM_CH*FLAG_W-1:0] shadow_flag;
  logic [NUM_CH*LEN_W-1:0]  shadow_length;
  logic [NUM_CH-1:0]        shadow_scramble;

  logic [CH_W:0]       cfg_slot;
  logic [CH_W:0]       rd_slot;
  logic                cfg_in_range;
  logic                rd_in_range;
  logic                imm;
  logic                accept;
  logic [NUM_CH-1:0]   cfg_sel;
  logic [NUM_CH-1:0]   wr_en;
  logic [NUM_CH-1:0]   imm_en;
  logic [NUM_CH-1:0]   apply_en;
  logic [HEAD_W-1:0]   rd_head_d;
  logic [FLAG_W-1:0]   rd_flag_d;
  logic [LEN_W-1:0]    rd_length_d;
  logic                rd_scramble_d;

  // Channel numbers are rebased at one extra bit so channels below CH_BASE wrap high and fail the range test.
  assign cfg_slot     = {1'b0, cfg.cfg_channel} - BASE_X;
  assign cfg_in_range = ({1'b0, cfg.cfg_channel} >= BASE_X) && (cfg_slot < NUM_X);
  assign rd_slot      = {1'b0, rd_channel} - BASE_X;
  assign rd_in_range  = ({1'b0, rd_channel} >= BASE_X) && (rd_slot < NUM_X);

`ifdef SRC_PARA_IMMEDIATE_EN
  assign imm = cfg.cfg_immediate;
`else
  assign imm = 1'b0;
`endif

  always_comb begin
    cfg_sel  = '0;
    apply_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_sel[i]  = cfg_in_range && (cfg_slot == (CH_W+1)'(i));
      apply_en[i] = (state_q[i] == ARMED) && pkt_boundary[i];
    end
  end

  assign accept = cfg.cfg_valid && cfg.cfg_ready;
  assign wr_en  = accept ? cfg_sel : '0;
  assign imm_en = imm ? wr_en : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An immediate write lands in the active set, so it leaves the slot idle even if a boundary arrives too.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en[i]) state_d[i] = imm ? IDLE : ARMED;
      else if (apply_en[i]) state_d[i] = IDLE;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_CH; i++) pending[i] = (state_q[i] == ARMED);
    cfg.cfg_ready = !rst && (!cfg_in_range || imm || ((pending & cfg_sel) == '0));
  end

  always_comb begin
    rd_head_d     = '0;
    rd_flag_d     = '0;
    rd_length_d   = '0;
    rd_scramble_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_in_range && (rd_slot == (CH_W+1)'(i))) begin
        rd_head_d     = act_head[i*HEAD_W +: HEAD_W];
        rd_flag_d     = act_flag[i*FLAG_W +: FLAG_W];
        rd_length_d   = act_length[i*LEN_W +: LEN_W];
        rd_scramble_d = act_scramble[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_head     <= '0;
      shadow_flag     <= '0;
      shadow_length   <= '0;
      shadow_scramble <= '0;
      act_head        <= '0;
      act_flag        <= '0;
      act_length      <= '0;
      act_scramble    <= '0;
      updated         <= '0;
      cfg.cfg_err     <= 1'b0;
      rd_head         <= '0;
      rd_flag         <= '0;
      rd_length       <= '0;
      rd_scramble     <= 1'b0;
    end else begin
      cfg.cfg_err <= accept && !cfg_in_range;
      updated     <= apply_en | imm_en;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en[i]) begin
          shadow_head[i*HEAD_W +: HEAD_W] <= cfg.cfg_head;
          shadow_flag[i*FLAG_W +: FLAG_W] <= cfg.cfg_flag;
          shadow_length[i*LEN_W +: LEN_W] <= cfg.cfg_length;
          shadow_scramble[i]              <= cfg.cfg_scramble;
        end
        if (imm_en[i]) begin
          act_head[i*HEAD_W +: HEAD_W] <= cfg.cfg_head;
          act_flag[i*FLAG_W +: FLAG_W] <= cfg.cfg_flag;
          act_length[i*LEN_W +: LEN_W] <= cfg.cfg_length;
          act_scramble[i]              <= cfg.cfg_scramble;
        end else if (apply_en[i]) begin
          act_head[i*HEAD_W +: HEAD_W] <= shadow_head[i*HEAD_W +: HEAD_W];
          act_flag[i*FLAG_W +: FLAG_W] <= shadow_flag[i*FLAG_W +: FLAG_W];
          act_length[i*LEN_W +: LEN_W] <= shadow_length[i*LEN_W +: LEN_W];
          act_scramble[i]              <= shadow_scramble[i];
        end
      end
      rd_head     <= rd_head_d;
      rd_flag     <= rd_flag_d;
      rd_length   <= rd_length_d;
      rd_scramble <= rd_scramble_d;
    end
  end

endmodule
